vga_rx_monitor: RTL and testbench
=================================

# vga_rx_monitor

Receive-side checker for the breakout VGA output. It samples `hsync`/`vsync`/`rgb` on `vga_clk`, recovers line and frame position, and checks the sync timing against the 640x480@60 raster. It re-emits each active pixel with its `pix_x`/`pix_y` coordinates and accumulates a per-frame pixel sum. It sits beside the VGA output path as the sink end of that interface, in simulation benches and as an optional on-chip self-check.

## Interface
Parameters:
- `H_SYNC` 96, `H_BACK` 48, `H_VALID` 640, `H_FRONT` 16 — horizontal timing, in pixel clocks.
- `V_SYNC` 2, `V_BACK` 33, `V_VALID` 480, `V_FRONT` 10 — vertical timing, in lines.
- `SYNC_ACT` 1 — active level of both syncs.

Ports:
- `vga_clk` in 1 — pixel clock; the only clock.
- `sys_rst_n` in 1 — synchronous, active-low reset.
- `hsync` in 1 — horizontal sync under test.
- `vsync` in 1 — vertical sync under test.
- `rgb` in 16 — RGB565 pixel under test.
- `err_clr` in 1 — clears the sticky `err` bits.
- `pix_valid` out 1 — current outputs are an active-window pixel.
- `pix_x` out 10 — column, 0..639.
- `pix_y` out 10 — row, 0..479.
- `pix_data` out 16 — captured `rgb`.
- `frame_done` out 1 — one-cycle pulse when a clean frame completes.
- `frame_sum` out 32 — sum of all `rgb` values in the last clean frame, modulo 2^32.
- `err` out 3 — sticky error flags: {blank_err, v_err, h_err}.
- `locked` out 1 — monitor is in LOCKED.

## Operation
- Stage 1 registers `hsync`, `vsync`, `rgb`. An active edge is a registered sync going inactive→active.
- **h_cnt (10b):** 0 on the hsync active-edge cycle, +1 otherwise. Saturates at 1023.
- **v_cnt (10b):** 0 on a vsync active edge; +1 on every other hsync active edge. Saturates at 1023.
- Totals: H_TOTAL=800, V_TOTAL=525.
- **h_err:**
  - at an hsync active edge, previous h_cnt ≠ H_TOTAL-1 (skipped for the first edge after IDLE);
  - at an hsync inactive edge, h_cnt ≠ H_SYNC;
  - h_cnt reaches H_TOTAL without an edge.
- **v_err:**
  - a vsync active edge that does not coincide with an hsync active edge;
  - at a vsync active edge, previous v_cnt ≠ V_TOTAL-1 (skipped in IDLE);
  - v_cnt reaches V_TOTAL.
- **blank_err:** `rgb` ≠ 0 while outside the active window, in SYNCING or LOCKED.
- **Active window:** h_cnt in [H_SYNC+H_BACK, +H_VALID-1] and v_cnt in [V_SYNC+V_BACK, +V_VALID-1].
  - pix_x = h_cnt-144, pix_y = v_cnt-35.
  - `pix_valid` asserts only in SYNCING or LOCKED.
- **FSM:**
  - IDLE → SYNCING on a vsync active edge.
  - SYNCING → LOCKED on the next vsync active edge, if no error event occurred since entering SYNCING.
  - Any error event in SYNCING or LOCKED → IDLE.
  - `locked` = (state == LOCKED).
- **Accumulator (32b):** cleared on every vsync active edge; adds `rgb` of every valid pixel; wraps modulo 2^32.
- **Frame completion:** on a vsync active edge in SYNCING or LOCKED that closes an error-free frame:
  - latch accumulator → `frame_sum`;
  - pulse `frame_done`.
  - A tainted frame gives no pulse, and `frame_sum` holds.
- **err bits:** sticky. `err_clr` zeroes them next cycle; a new error in the same cycle as `err_clr` wins, and that bit stays 1.

## Timing
- Latency: `rgb` sampled at cycle t → `pix_data`, `pix_x`, `pix_y`, `pix_valid` at t+2, all mutually aligned.
- vsync first active at cycle t → `frame_done`/`frame_sum` at t+2. `frame_sum` then holds until the next pulse.
- Error input condition at cycle t → `err` bit set and `locked`=0 at t+2.
- Reset values: all outputs 0, FSM IDLE, counters 0.
- Reset asserted mid-frame: all outputs 0 on the next edge. Relock requires two further vsync active edges.
- Simultaneous vsync and hsync active edges are the normal case: v_cnt←0, h_cnt←0.

## Structure
- Shared package/include `breakout_vga_pkg`:
  - H_*/V_* timing constants, H_TOTAL, V_TOTAL;
  - FSM state encodings (IDLE, SYNCING, LOCKED);
  - `err` bit indices.
- VGA_Ctrl uses the same timing constants.
- One sub-module, `vga_sync_edge`: input register plus active/inactive edge detect with `SYNC_ACT` polarity. Instantiated for hsync and for vsync.

## Test plan
- Reset, then two clean frames with constant rgb=16'h0001:
  - `locked`=1 after the 2nd vsync edge;
  - `frame_done` pulse with `frame_sum`=32'h0004B000;
  - `err`=0.
- rgb={6'd0,x} from the generator:
  - first pix_valid shows pix_x=0, pix_y=0, pix_data=0;
  - last shows pix_x=639, pix_y=479, pix_data=16'd639;
  - exactly 307200 valid cycles per frame.
- One 799-cycle line in a locked stream:
  - err=3'b001 and locked=0 two cycles after the short edge;
  - no `frame_done` for that frame;
  - locked again at the 2nd vsync edge after the error.
- rgb=16'hFFFF for one cycle at h_cnt=10 → err[2]=1; pix_valid never asserts for that cycle.
- `err_clr` coincident with a v_err event → err[1] stays 1; `err_clr` alone next cycle → err=0.
- `sys_rst_n` low for one cycle at mid-frame (v_cnt=200) → all outputs 0 next cycle; relock after two clean vsync edges.

Source files
------------

// File: rtl/breakout_vga_pkg.sv
// Shared VGA raster constants, monitor states and error bit positions.
package breakout_vga_pkg;

    localparam int H_SYNC_DEF  = 96;
    localparam int H_BACK_DEF  = 48;
    localparam int H_VALID_DEF = 640;
    localparam int H_FRONT_DEF = 16;
    localparam int V_SYNC_DEF  = 2;
    localparam int V_BACK_DEF  = 33;
    localparam int V_VALID_DEF = 480;
    localparam int V_FRONT_DEF = 10;

    localparam int H_TOTAL_DEF = H_SYNC_DEF + H_BACK_DEF + H_VALID_DEF + H_FRONT_DEF;
    localparam int V_TOTAL_DEF = V_SYNC_DEF + V_BACK_DEF + V_VALID_DEF + V_FRONT_DEF;

    localparam int CNT_W = 10;
    typedef logic [CNT_W-1:0] cnt_t;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SYNCING = 2'd1,
        ST_LOCKED  = 2'd2
    } mon_state_t;

    localparam int ERR_H     = 0;
    localparam int ERR_V     = 1;
    localparam int ERR_BLANK = 2;

endpackage

// File: rtl/vga_sync_edge.sv
// Sync input register with active / inactive edge detection.
module vga_sync_edge #(
    parameter logic SYNC_ACT = 1'b1
) (
    input  logic vga_clk,
    input  logic sys_rst_n,
    input  logic sync,
    output logic act_edge,
    output logic inact_edge
);

    logic sync_q;
    logic sync_qq;

    // Both taps reset to the inactive level so reset never fakes an edge.
    always_ff @(posedge vga_clk) begin
        if (!sys_rst_n) begin
            sync_q  <= ~SYNC_ACT;
            sync_qq <= ~SYNC_ACT;
        end else begin
            sync_q  <= sync;
            sync_qq <= sync_q;
        end
    end

    assign act_edge   = (sync_q == SYNC_ACT) && (sync_qq != SYNC_ACT);
    assign inact_edge = (sync_q != SYNC_ACT) && (sync_qq == SYNC_ACT);

endmodule

// File: rtl/vga_rx_monitor.sv
// VGA sink-side checker: recovers raster position, checks sync timing,
// re-emits active pixels and sums each clean frame.
module vga_rx_monitor
    import breakout_vga_pkg::*;
#(
    parameter int   H_SYNC   = H_SYNC_DEF,
    parameter int   H_BACK   = H_BACK_DEF,
    parameter int   H_VALID  = H_VALID_DEF,
    parameter int   H_FRONT  = H_FRONT_DEF,
    parameter int   V_SYNC   = V_SYNC_DEF,
    parameter int   V_BACK   = V_BACK_DEF,
    parameter int   V_VALID  = V_VALID_DEF,
    parameter int   V_FRONT  = V_FRONT_DEF,
    parameter logic SYNC_ACT = 1'b1
) (
    input  logic        vga_clk,
    input  logic        sys_rst_n,
    input  logic        hsync,
    input  logic        vsync,
    input  logic [15:0] rgb,
    input  logic        err_clr,
    output logic        pix_valid,
    output logic [9:0]  pix_x,
    output logic [9:0]  pix_y,
    output logic [15:0] pix_data,
    output logic        frame_done,
    output logic [31:0] frame_sum,
    output logic [2:0]  err,
    output logic        locked
);

    localparam int H_TOTAL = H_SYNC + H_BACK + H_VALID + H_FRONT;
    localparam int V_TOTAL = V_SYNC + V_BACK + V_VALID + V_FRONT;

    localparam cnt_t H_TOT  = cnt_t'(H_TOTAL);
    localparam cnt_t H_LAST = cnt_t'(H_TOTAL - 1);
    localparam cnt_t H_SYN  = cnt_t'(H_SYNC);
    localparam cnt_t H_ACT0 = cnt_t'(H_SYNC + H_BACK);
    localparam cnt_t H_ACTN = cnt_t'(H_SYNC + H_BACK + H_VALID - 1);
    localparam cnt_t V_TOT  = cnt_t'(V_TOTAL);
    localparam cnt_t V_LAST = cnt_t'(V_TOTAL - 1);
    localparam cnt_t V_ACT0 = cnt_t'(V_SYNC + V_BACK);
    localparam cnt_t V_ACTN = cnt_t'(V_SYNC + V_BACK + V_VALID - 1);
    localparam cnt_t CNT_MAX = '1;

    logic h_act;
    logic h_inact;
    logic v_act;
    logic v_inact_unused;

    vga_sync_edge #(.SYNC_ACT(SYNC_ACT)) u_hsync (
        .vga_clk    (vga_clk),
        .sys_rst_n  (sys_rst_n),
        .sync       (hsync),
        .act_edge   (h_act),
        .inact_edge (h_inact)
    );

    vga_sync_edge #(.SYNC_ACT(SYNC_ACT)) u_vsync (
        .vga_clk    (vga_clk),
        .sys_rst_n  (sys_rst_n),
        .sync       (vsync),
        .act_edge   (v_act),
        .inact_edge (v_inact_unused)
    );

    mon_state_t  state;
    logic [15:0] rgb_q;
    cnt_t        h_cnt;
    cnt_t        v_cnt;
    cnt_t        h_cur;
    cnt_t        v_cur;
    logic [31:0] acc;

    // h_cur/v_cur are the position of the sample now held in rgb_q.
    always_comb begin
        h_cur = h_cnt;
        if (h_act)
            h_cur = '0;
        else if (h_cnt != CNT_MAX)
            h_cur = h_cnt + cnt_t'(1);
        v_cur = v_cnt;
        if (v_act)
            v_cur = '0;
        else if (h_act && v_cnt != CNT_MAX)
            v_cur = v_cnt + cnt_t'(1);
    end

    logic       run;
    logic       in_win;
    logic       pix_ok;
    logic       frame_ok;
    logic       any_err;
    logic [2:0] new_err;

    assign run    = (state != ST_IDLE);
    assign in_win = (h_cur >= H_ACT0) && (h_cur <= H_ACTN)
                 && (v_cur >= V_ACT0) && (v_cur <= V_ACTN);
    assign pix_ok = run && in_win;

    always_comb begin
        new_err = '0;
        new_err[ERR_H] = run && ((h_act && h_cnt != H_LAST)
                              || (h_inact && h_cur != H_SYN)
                              || (h_cur == H_TOT));
        new_err[ERR_V] = run && ((v_act && !h_act)
                              || (v_act && v_cnt != V_LAST)
                              || (v_cur == V_TOT && v_cnt != V_TOT));
        new_err[ERR_BLANK] = run && !in_win && (rgb_q != 16'd0);
    end

    assign any_err  = |new_err;
    assign frame_ok = run && v_act && !any_err;

    always_ff @(posedge vga_clk) begin
        if (!sys_rst_n) begin
            rgb_q      <= '0;
            h_cnt      <= '0;
            v_cnt      <= '0;
            acc        <= '0;
            pix_valid  <= 1'b0;
            pix_x      <= '0;
            pix_y      <= '0;
            pix_data   <= '0;
            frame_done <= 1'b0;
            frame_sum  <= '0;
            err        <= '0;
        end else begin
            rgb_q      <= rgb;
            h_cnt      <= h_cur;
            v_cnt      <= v_cur;
            pix_valid  <= pix_ok;
            pix_x      <= pix_ok ? h_cur - H_ACT0 : '0;
            pix_y      <= pix_ok ? v_cur - V_ACT0 : '0;
            pix_data   <= pix_ok ? rgb_q : '0;
            frame_done <= frame_ok;
            if (frame_ok)
                frame_sum <= acc;
            if (v_act)
                acc <= '0;
            else if (pix_ok)
                acc <= acc + {16'd0, rgb_q};
            // A fresh error outranks a simultaneous clear.
            err <= (err & ~{3{err_clr}}) | new_err;
        end
    end

    always_ff @(posedge vga_clk) begin
        if (!sys_rst_n) begin
            state  <= ST_IDLE;
            locked <= 1'b0;
        end else if (any_err) begin
            state  <= ST_IDLE;
            locked <= 1'b0;
        end else if (v_act) begin
            unique case (state)
                ST_IDLE: begin
                    state  <= ST_SYNCING;
                    locked <= 1'b0;
                end
                ST_SYNCING: begin
                    state  <= ST_LOCKED;
                    locked <= 1'b1;
                end
                ST_LOCKED: begin
                    state  <= ST_LOCKED;
                    locked <= 1'b1;
                end
                default: begin
                    state  <= ST_IDLE;
                    locked <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_vga_rx_monitor.sv
// Bench for vga_rx_monitor on a reduced raster with a pixel scoreboard.
module tb_vga_rx_monitor;

    localparam int HS = 8, HB = 4, HV = 16, HF = 4;
    localparam int VS = 2, VB = 3, VV = 8, VF = 2;
    localparam int HT = HS + HB + HV + HF;
    localparam int VT = VS + VB + VV + VF;
    localparam int XA = HS + HB;
    localparam int YA = VS + VB;
    localparam int FT = HT * VT;
    localparam logic [31:0] SUM_ONE = 32'(HV * VV);
    localparam logic [31:0] SUM_X   = 32'(VV * (HV * (HV - 1) / 2));

    logic        clk = 1'b0;
    logic        rst_n;
    logic        hsync;
    logic        vsync;
    logic [15:0] rgb;
    logic        err_clr;
    logic        pix_valid;
    logic [9:0]  pix_x;
    logic [9:0]  pix_y;
    logic [15:0] pix_data;
    logic        frame_done;
    logic [31:0] frame_sum;
    logic [2:0]  err;
    logic        locked;

    always #5 clk = ~clk;

    vga_rx_monitor #(
        .H_SYNC(HS), .H_BACK(HB), .H_VALID(HV), .H_FRONT(HF),
        .V_SYNC(VS), .V_BACK(VB), .V_VALID(VV), .V_FRONT(VF),
        .SYNC_ACT(1'b1)
    ) dut (
        .vga_clk    (clk),
        .sys_rst_n  (rst_n),
        .hsync      (hsync),
        .vsync      (vsync),
        .rgb        (rgb),
        .err_clr    (err_clr),
        .pix_valid  (pix_valid),
        .pix_x      (pix_x),
        .pix_y      (pix_y),
        .pix_data   (pix_data),
        .frame_done (frame_done),
        .frame_sum  (frame_sum),
        .err        (err),
        .locked     (locked)
    );

    typedef struct {
        logic [9:0]  x;
        logic [9:0]  y;
        logic [15:0] d;
    } px_t;

    px_t sb[$];
    int  checks = 0;
    int  failures = 0;
    int  gx = 0;
    int  gy = 0;
    int  mode = 0;
    bit  sb_on = 0;
    bit  short_ln = 0;
    bit  glitch_rgb = 0;
    bit  glitch_vs = 0;
    int  valid_cnt = 0;
    bit  seen_first = 0;
    px_t first_px;
    px_t last_px;

    // One raster cycle driven after posedge; DUT sampled at the negedge.
    task automatic drive_one();
        px_t e;
        bit  act;
        @(posedge clk);
        #1;
        act = (gx >= XA) && (gx < XA + HV) && (gy >= YA) && (gy < YA + VV);
        hsync = (gx < HS);
        vsync = (gy < VS) || glitch_vs;
        rgb = 16'd0;
        if (act)
            rgb = (mode == 1) ? 16'(gx - XA) : 16'd1;
        if (glitch_rgb)
            rgb = 16'hFFFF;
        if (sb_on && act) begin
            e.x = 10'(gx - XA);
            e.y = 10'(gy - YA);
            e.d = rgb;
            sb.push_back(e);
        end
        if (gx == HT - 1 || (short_ln && gx == HT - 2)) begin
            gx = 0;
            gy = (gy == VT - 1) ? 0 : gy + 1;
        end else begin
            gx++;
        end
        @(negedge clk);
        if (sb_on && pix_valid) begin
            valid_cnt++;
            checks++;
            if (sb.size() == 0) begin
                failures++;
                $display("FAIL pix_extra got x=%0d y=%0d d=%0h, expected no pixel",
                         pix_x, pix_y, pix_data);
            end else begin
                e = sb.pop_front();
                if ({pix_x, pix_y, pix_data} !== {e.x, e.y, e.d}) begin
                    failures++;
                    $display("FAIL pix_sb got x=%0d y=%0d d=%0h exp x=%0d y=%0d d=%0h",
                             pix_x, pix_y, pix_data, e.x, e.y, e.d);
                end
            end
            if (!seen_first) begin
                first_px.x = pix_x;
                first_px.y = pix_y;
                first_px.d = pix_data;
                seen_first = 1;
            end
            last_px.x = pix_x;
            last_px.y = pix_y;
            last_px.d = pix_data;
        end
    endtask

    task automatic drive_until(input int x, input int y);
        int n;
        n = 0;
        while (!(gx == x && gy == y) && n < 2 * FT) begin
            drive_one();
            n++;
        end
        if (!(gx == x && gy == y)) begin
            failures++;
            $display("FAIL drive_until position %0d,%0d not reached", x, y);
        end
    endtask

    // Leaves the bench two cycles past the next vsync active edge.
    task automatic to_vedge_plus2();
        drive_until(0, 0);
        repeat (3) drive_one();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        err_clr = 1'b0;
        gx = HS + 1;
        gy = 7;
        repeat (3) drive_one();
        checks++;
        if ({pix_valid, pix_x, pix_y, pix_data} !== 37'd0) begin
            failures++;
            $display("FAIL reset_pix got v=%0b x=%0d y=%0d d=%0h exp all 0",
                     pix_valid, pix_x, pix_y, pix_data);
        end
        checks++;
        if ({frame_done, frame_sum} !== 33'd0) begin
            failures++;
            $display("FAIL reset_frame got done=%0b sum=%0h exp 0", frame_done, frame_sum);
        end
        checks++;
        if ({err, locked} !== 4'd0) begin
            failures++;
            $display("FAIL reset_state got err=%0b locked=%0b exp 0", err, locked);
        end
        rst_n = 1'b1;
        gx = 0;
        gy = 0;
    endtask

    task automatic test_clean_frames();
        mode = 0;
        to_vedge_plus2();
        checks++;
        if ({locked, frame_done, frame_sum} !== 34'd0) begin
            failures++;
            $display("FAIL first_edge got locked=%0b done=%0b sum=%0h exp 0/0/0",
                     locked, frame_done, frame_sum);
        end
        to_vedge_plus2();
        checks++;
        if ({locked, frame_done} !== 2'b11) begin
            failures++;
            $display("FAIL lock2 got locked=%0b done=%0b exp 1/1", locked, frame_done);
        end
        checks++;
        if (frame_sum !== SUM_ONE) begin
            failures++;
            $display("FAIL sum_ones got %0h exp %0h", frame_sum, SUM_ONE);
        end
        checks++;
        if (err !== 3'b000) begin
            failures++;
            $display("FAIL clean_err got %0b exp 000", err);
        end
        drive_one();
        checks++;
        if (frame_done !== 1'b0 || frame_sum !== SUM_ONE) begin
            failures++;
            $display("FAIL done_pulse got done=%0b sum=%0h exp 0/%0h",
                     frame_done, frame_sum, SUM_ONE);
        end
    endtask

    task automatic test_pixels();
        to_vedge_plus2();
        checks++;
        if (frame_done !== 1'b1 || frame_sum !== SUM_ONE) begin
            failures++;
            $display("FAIL frame3 got done=%0b sum=%0h exp 1/%0h",
                     frame_done, frame_sum, SUM_ONE);
        end
        mode = 1;
        sb_on = 1;
        valid_cnt = 0;
        seen_first = 0;
        to_vedge_plus2();
        sb_on = 0;
        mode = 0;
        checks++;
        if (valid_cnt != HV * VV) begin
            failures++;
            $display("FAIL valid_count got %0d exp %0d", valid_cnt, HV * VV);
        end
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL sb_left got %0d exp 0", sb.size());
        end
        checks++;
        if ({first_px.x, first_px.y, first_px.d} !== 36'd0) begin
            failures++;
            $display("FAIL first_px got x=%0d y=%0d d=%0h exp 0/0/0",
                     first_px.x, first_px.y, first_px.d);
        end
        checks++;
        if (last_px.x !== 10'(HV - 1) || last_px.y !== 10'(VV - 1)
            || last_px.d !== 16'(HV - 1)) begin
            failures++;
            $display("FAIL last_px got x=%0d y=%0d d=%0h exp %0d/%0d/%0h",
                     last_px.x, last_px.y, last_px.d, HV - 1, VV - 1, HV - 1);
        end
        checks++;
        if (frame_done !== 1'b1 || frame_sum !== SUM_X) begin
            failures++;
            $display("FAIL sum_ramp got done=%0b sum=%0h exp 1/%0h",
                     frame_done, frame_sum, SUM_X);
        end
    endtask

    task automatic test_short_line();
        drive_until(0, 6);
        short_ln = 1;
        drive_until(0, 7);
        short_ln = 0;
        drive_one();
        drive_one();
        checks++;
        if (err !== 3'b000 || locked !== 1'b1) begin
            failures++;
            $display("FAIL short_t1 got err=%0b locked=%0b exp 000/1", err, locked);
        end
        drive_one();
        checks++;
        if (err !== 3'b001 || locked !== 1'b0) begin
            failures++;
            $display("FAIL short_t2 got err=%0b locked=%0b exp 001/0", err, locked);
        end
        to_vedge_plus2();
        checks++;
        if (frame_done !== 1'b0 || locked !== 1'b0 || frame_sum !== SUM_X) begin
            failures++;
            $display("FAIL tainted got done=%0b locked=%0b sum=%0h exp 0/0/%0h",
                     frame_done, locked, frame_sum, SUM_X);
        end
        to_vedge_plus2();
        checks++;
        if (locked !== 1'b1 || frame_done !== 1'b1 || frame_sum !== SUM_ONE) begin
            failures++;
            $display("FAIL relock got locked=%0b done=%0b sum=%0h exp 1/1/%0h",
                     locked, frame_done, frame_sum, SUM_ONE);
        end
        checks++;
        if (err !== 3'b001) begin
            failures++;
            $display("FAIL sticky got %0b exp 001", err);
        end
    endtask

    task automatic test_blank();
        err_clr = 1'b1;
        drive_one();
        err_clr = 1'b0;
        checks++;
        if (err !== 3'b000) begin
            failures++;
            $display("FAIL clr_alone got %0b exp 000", err);
        end
        drive_until(10, 8);
        glitch_rgb = 1;
        drive_one();
        glitch_rgb = 0;
        drive_one();
        checks++;
        if (err !== 3'b000 || locked !== 1'b1) begin
            failures++;
            $display("FAIL blank_t1 got err=%0b locked=%0b exp 000/1", err, locked);
        end
        drive_one();
        checks++;
        if (err !== 3'b100 || pix_valid !== 1'b0 || locked !== 1'b0) begin
            failures++;
            $display("FAIL blank_t2 got err=%0b valid=%0b locked=%0b exp 100/0/0",
                     err, pix_valid, locked);
        end
    endtask

    task automatic test_err_clr();
        to_vedge_plus2();
        to_vedge_plus2();
        err_clr = 1'b1;
        drive_one();
        err_clr = 1'b0;
        checks++;
        if (err !== 3'b000 || locked !== 1'b1) begin
            failures++;
            $display("FAIL pre_verr got err=%0b locked=%0b exp 000/1", err, locked);
        end
        drive_until(10, 8);
        glitch_vs = 1;
        drive_one();
        glitch_vs = 0;
        drive_one();
        err_clr = 1'b1;
        drive_one();
        checks++;
        if (err !== 3'b010 || locked !== 1'b0) begin
            failures++;
            $display("FAIL verr_vs_clr got err=%0b locked=%0b exp 010/0", err, locked);
        end
        drive_one();
        err_clr = 1'b0;
        checks++;
        if (err !== 3'b000) begin
            failures++;
            $display("FAIL clr_after got %0b exp 000", err);
        end
    endtask

    task automatic test_reset_mid();
        to_vedge_plus2();
        to_vedge_plus2();
        checks++;
        if (locked !== 1'b1) begin
            failures++;
            $display("FAIL pre_rst_lock got %0b exp 1", locked);
        end
        drive_until(XA + 5, YA + 2);
        rst_n = 1'b0;
        drive_one();
        rst_n = 1'b1;
        checks++;
        if ({pix_valid, pix_x, pix_y, pix_data, frame_done, frame_sum, err, locked}
            !== 74'd0) begin
            failures++;
            $display("FAIL mid_rst got v=%0b x=%0d y=%0d d=%0h done=%0b sum=%0h err=%0b lk=%0b exp all 0",
                     pix_valid, pix_x, pix_y, pix_data, frame_done, frame_sum, err, locked);
        end
        to_vedge_plus2();
        checks++;
        if (locked !== 1'b0 || frame_done !== 1'b0) begin
            failures++;
            $display("FAIL rst_edge1 got locked=%0b done=%0b exp 0/0", locked, frame_done);
        end
        to_vedge_plus2();
        checks++;
        if (locked !== 1'b1 || frame_done !== 1'b1 || frame_sum !== SUM_ONE
            || err !== 3'b000) begin
            failures++;
            $display("FAIL rst_relock got locked=%0b done=%0b sum=%0h err=%0b exp 1/1/%0h/000",
                     locked, frame_done, frame_sum, err, SUM_ONE);
        end
    endtask

    initial begin
        hsync = 1'b0;
        vsync = 1'b0;
        rgb = 16'd0;
        test_reset();
        test_clean_frames();
        test_pixels();
        test_short_line();
        test_blank();
        test_err_clr();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1);
    end

endmodule
